// File: rtl/seven_segments_rx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : seven_segments_rx                                              |
// | Brief   : Recovers two stable active-high digit patterns from a          |
// |           multiplexed active-low seven-segment bus. Optional glyph       |
// |           decoder enabled by defining SEV_SEG_RX_DECODE_EN.              |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module seven_segments_rx #(
  parameter int STABLE_COUNT = 4,
  parameter int SETTLE       = 0,
  parameter int TIMEOUT      = 100000
) (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic [6:0] i_sev_segments,
  input  logic       i_sev_seg_cathode,
  output logic [6:0] o_segments_digit_0,
  output logic [6:0] o_segments_digit_1,
  output logic       o_update,
  output logic       o_link_active
`ifdef SEV_SEG_RX_DECODE_EN
  ,
  output logic [3:0] o_hex_digit_0,
  output logic [3:0] o_hex_digit_1,
  output logic [1:0] o_hex_valid
`endif
);

  localparam int c_run_w = $clog2(STABLE_COUNT + 1);
  localparam int c_set_w = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
  localparam int c_tmo_w = $clog2(TIMEOUT + 1);
  localparam logic [c_run_w-1:0] c_run_max = c_run_w'(STABLE_COUNT);
  localparam logic [c_tmo_w-1:0] c_tmo_max = c_tmo_w'(TIMEOUT);

  logic [6:0] seg_meta_q, seg_meta_d, seg_sync_q, seg_sync_d;
  logic       cath_meta_q, cath_meta_d, cath_sync_q, cath_sync_d;
  logic       phase_prev_q, phase_prev_d;
  logic [c_set_w-1:0] settle_q, settle_d;
  logic [6:0]         cand_q [2];
  logic [6:0]         cand_d [2];
  logic [c_run_w-1:0] run_q  [2];
  logic [c_run_w-1:0] run_d  [2];
  logic [6:0]         out_q  [2];
  logic [6:0]         out_d  [2];
  logic               update_q, update_d;
  logic [c_tmo_w-1:0] tmo_q, tmo_d;
  logic               link_q, link_d;

  logic [6:0] sample;
  logic       phase;
  logic       phase_edge;
  logic       keep;

  always_comb begin
    seg_meta_d   = i_sev_segments;
    seg_sync_d   = seg_meta_q;
    cath_meta_d  = i_sev_seg_cathode;
    cath_sync_d  = cath_meta_q;
    sample       = ~seg_sync_q;
    phase        = cath_sync_q;
    phase_edge   = phase ^ phase_prev_q;
    phase_prev_d = phase;
  end

  // The transition-cycle sample counts as the first of the SETTLE discarded ones.
  always_comb begin
    settle_d = settle_q;
    keep     = 1'b1;
    if (phase_edge) begin
      if (SETTLE > 0) begin
        settle_d = c_set_w'(SETTLE - 1);
        keep     = 1'b0;
      end
    end else if (settle_q != '0) begin
      settle_d = settle_q - c_set_w'(1);
      keep     = 1'b0;
    end
  end

  // Digit 0 is on the bus while the cathode is high; each digit tracks its own run.
  always_comb begin
    for (int d = 0; d < 2; d++) begin
      cand_d[d] = cand_q[d];
      run_d[d]  = run_q[d];
      out_d[d]  = out_q[d];
      if ((run_q[d] == c_run_max) && (cand_q[d] != out_q[d])) begin
        out_d[d] = cand_q[d];
      end
      if (keep && (phase == (d == 0))) begin
        if (sample == cand_q[d]) begin
          if (run_q[d] != c_run_max) begin
            run_d[d] = run_q[d] + c_run_w'(1);
          end
        end else begin
          cand_d[d] = sample;
          run_d[d]  = c_run_w'(1);
        end
      end
    end
    update_d = (out_d[0] != out_q[0]) || (out_d[1] != out_q[1]);
  end

  always_comb begin
    tmo_d  = tmo_q;
    link_d = link_q;
    if (phase_edge) begin
      tmo_d  = '0;
      link_d = 1'b1;
    end else begin
      if (tmo_q != c_tmo_max) begin
        tmo_d = tmo_q + c_tmo_w'(1);
      end
      if (tmo_d == c_tmo_max) begin
        link_d = 1'b0;
      end
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      seg_meta_q   <= 7'h7F;
      seg_sync_q   <= 7'h7F;
      cath_meta_q  <= 1'b0;
      cath_sync_q  <= 1'b0;
      phase_prev_q <= 1'b0;
      settle_q     <= '0;
      for (int d = 0; d < 2; d++) begin
        cand_q[d] <= '0;
        run_q[d]  <= '0;
        out_q[d]  <= '0;
      end
      update_q <= 1'b0;
      tmo_q    <= '0;
      link_q   <= 1'b0;
    end else begin
      seg_meta_q   <= seg_meta_d;
      seg_sync_q   <= seg_sync_d;
      cath_meta_q  <= cath_meta_d;
      cath_sync_q  <= cath_sync_d;
      phase_prev_q <= phase_prev_d;
      settle_q     <= settle_d;
      for (int d = 0; d < 2; d++) begin
        cand_q[d] <= cand_d[d];
        run_q[d]  <= run_d[d];
        out_q[d]  <= out_d[d];
      end
      update_q <= update_d;
      tmo_q    <= tmo_d;
      link_q   <= link_d;
    end
  end

  assign o_segments_digit_0 = out_q[0];
  assign o_segments_digit_1 = out_q[1];
  assign o_update           = update_q;
  assign o_link_active      = link_q;

`ifdef SEV_SEG_RX_DECODE_EN
  // Returns {legal, value}; patterns are in gfedcba bit order.
  function automatic logic [4:0] decode_glyph(input logic [6:0] g);
    logic [4:0] r;
    r = 5'd0;
    case (g)
      7'h3F: r = {1'b1, 4'h0};
      7'h06: r = {1'b1, 4'h1};
      7'h5B: r = {1'b1, 4'h2};
      7'h4F: r = {1'b1, 4'h3};
      7'h66: r = {1'b1, 4'h4};
      7'h6D: r = {1'b1, 4'h5};
      7'h7D: r = {1'b1, 4'h6};
      7'h07: r = {1'b1, 4'h7};
      7'h7F: r = {1'b1, 4'h8};
      7'h6F: r = {1'b1, 4'h9};
      7'h77: r = {1'b1, 4'hA};
      7'h7C: r = {1'b1, 4'hB};
      7'h39: r = {1'b1, 4'hC};
      7'h5E: r = {1'b1, 4'hD};
      7'h79: r = {1'b1, 4'hE};
      7'h71: r = {1'b1, 4'hF};
      default: r = 5'd0;
    endcase
    return r;
  endfunction

  logic [3:0] hex0_q, hex0_d, hex1_q, hex1_d;
  logic [1:0] hex_valid_q, hex_valid_d;

  always_comb begin
    {hex_valid_d[0], hex0_d} = decode_glyph(out_q[0]);
    {hex_valid_d[1], hex1_d} = decode_glyph(out_q[1]);
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      hex0_q      <= '0;
      hex1_q      <= '0;
      hex_valid_q <= '0;
    end else begin
      hex0_q      <= hex0_d;
      hex1_q      <= hex1_d;
      hex_valid_q <= hex_valid_d;
    end
  end

  assign o_hex_digit_0 = hex0_q;
  assign o_hex_digit_1 = hex1_q;
  assign o_hex_valid   = hex_valid_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_seven_segments_rx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_seven_segments_rx                                           |
// | Brief   : Randomized bench for seven_segments_rx against a sample-queue  |
// |           reference model; decode checks follow SEV_SEG_RX_DECODE_EN.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_seven_segments_rx;

  localparam int P_N   = 3;
  localparam int P_SET = 1;
  localparam int P_TMO = 30;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] pins_seg;
  logic       pins_cath;
  logic [6:0] dig0, dig1;
  logic       upd, link;
`ifdef SEV_SEG_RX_DECODE_EN
  logic [3:0] hex0, hex1;
  logic [1:0] hexv;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  seven_segments_rx #(.STABLE_COUNT(P_N), .SETTLE(P_SET), .TIMEOUT(P_TMO)) dut (
    .i_clock           (clk),
    .i_reset           (rst),
    .i_sev_segments    (pins_seg),
    .i_sev_seg_cathode (pins_cath),
    .o_segments_digit_0(dig0),
    .o_segments_digit_1(dig1),
    .o_update          (upd),
    .o_link_active     (link)
`ifdef SEV_SEG_RX_DECODE_EN
    ,
    .o_hex_digit_0     (hex0),
    .o_hex_digit_1     (hex1),
    .o_hex_valid       (hexv)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: accepted samples per digit kept as a queue of the last P_N values.
  logic [6:0] m_s1_seg, m_s2_seg;
  logic       m_s1_cath, m_s2_cath, m_prev;
  logic [6:0] m_q0[$];
  logic [6:0] m_q1[$];
  logic [6:0] m_out0, m_out1, m_new0, m_new1, m_smp;
  logic       m_upd, m_link, m_seen, m_valid = 1'b0, m_tr, m_ph;
  int         m_since, m_last, m_cyc = 0;

  function automatic logic run_stable(input logic [6:0] q[$]);
    if (q.size() < P_N) return 1'b0;
    foreach (q[i]) if (q[i] != q[0]) return 1'b0;
    return 1'b1;
  endfunction

`ifdef SEV_SEG_RX_DECODE_EN
  logic [6:0] glyphs [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  logic [4:0] m_dec0, m_dec1;
  function automatic logic [4:0] glyph_value(input logic [6:0] p);
    for (int i = 0; i < 16; i++) if (glyphs[i] == p) return {1'b1, 4'(i)};
    return 5'd0;
  endfunction
`endif

  always @(posedge clk) begin
    m_valid = 1'b1;
    m_cyc++;
    if (rst) begin
      m_s1_seg = 7'h7F; m_s2_seg = 7'h7F; m_s1_cath = 1'b0; m_s2_cath = 1'b0;
      m_prev = 1'b0; m_since = P_SET; m_q0.delete(); m_q1.delete();
      m_out0 = '0; m_out1 = '0; m_upd = 1'b0; m_link = 1'b0; m_seen = 1'b0; m_last = 0;
`ifdef SEV_SEG_RX_DECODE_EN
      m_dec0 = '0; m_dec1 = '0;
`endif
    end else begin
      m_smp = ~m_s2_seg;
      m_ph  = m_s2_cath;
      m_tr  = (m_ph != m_prev);
`ifdef SEV_SEG_RX_DECODE_EN
      m_dec0 = glyph_value(m_out0);
      m_dec1 = glyph_value(m_out1);
`endif
      m_new0 = (run_stable(m_q0) && m_q0[0] != m_out0) ? m_q0[0] : m_out0;
      m_new1 = (run_stable(m_q1) && m_q1[0] != m_out1) ? m_q1[0] : m_out1;
      m_upd  = (m_new0 != m_out0) || (m_new1 != m_out1);
      m_out0 = m_new0;
      m_out1 = m_new1;
      if (m_tr) m_since = 0;
      else if (m_since < 1000) m_since++;
      if (m_since >= P_SET) begin
        if (m_ph) begin m_q0.push_back(m_smp); if (m_q0.size() > P_N) void'(m_q0.pop_front()); end
        else      begin m_q1.push_back(m_smp); if (m_q1.size() > P_N) void'(m_q1.pop_front()); end
      end
      if (m_tr) begin m_seen = 1'b1; m_last = m_cyc; end
      m_link = m_seen && ((m_cyc - m_last) < P_TMO);
      m_prev = m_ph;
      m_s2_seg = m_s1_seg; m_s2_cath = m_s1_cath;
      m_s1_seg = pins_seg; m_s1_cath = pins_cath;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check_eq("digit0", 32'(dig0), 32'(m_out0));
      check_eq("digit1", 32'(dig1), 32'(m_out1));
      check_eq("update", 32'(upd), 32'(m_upd));
      check_eq("link",   32'(link), 32'(m_link));
`ifdef SEV_SEG_RX_DECODE_EN
      check_eq("hex0", 32'({hexv[0], hex0}), 32'(m_dec0));
      check_eq("hex1", 32'({hexv[1], hex1}), 32'(m_dec1));
`endif
    end
  end

  // Drives one multiplexed phase with an active-high pattern for a number of cycles.
  task automatic drive(input logic [6:0] pat, input logic cath, input int cycles);
    pins_seg  = ~pat;
    pins_cath = cath;
    repeat (cycles) @(negedge clk);
  endtask

  logic [6:0] pool [6] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h49, 7'h6D};

  initial begin
    rst = 1'b1; pins_seg = 7'h7F; pins_cath = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_digit0", 32'(dig0), 32'h0);
    check_eq("rst_link", 32'(link), 32'h0);
    rst = 1'b0;
    repeat (P_TMO + 5) @(negedge clk);
    check_eq("idle_digits", 32'({dig1, dig0}), 32'h0);
    check_eq("idle_link", 32'(link), 32'h0);

    // Loopback 06/5B, two cycles per phase so one sample per phase survives settling.
    for (int i = 0; i < 12; i++) begin drive(7'h06, 1'b1, 2); drive(7'h5B, 1'b0, 2); end
    check_eq("loop_digit0", 32'(dig0), 32'h06);
    check_eq("loop_digit1", 32'(dig1), 32'h5B);
    check_eq("loop_link", 32'(link), 32'h1);
`ifdef SEV_SEG_RX_DECODE_EN
    check_eq("loop_hex", 32'({hexv, hex1, hex0}), 32'h321);
`endif

    // Short glitch on digit 0 must not be captured.
    for (int i = 0; i < P_N - 1; i++) begin drive(7'h3F, 1'b1, 2); drive(7'h5B, 1'b0, 2); end
    for (int i = 0; i < 4; i++) begin drive(7'h06, 1'b1, 2); drive(7'h5B, 1'b0, 2); end
    check_eq("glitch_digit0", 32'(dig0), 32'h06);

    // Frozen cathode: link drops, digits held, then recovers.
    drive(7'h06, 1'b1, P_TMO + 5);
    check_eq("frozen_link", 32'(link), 32'h0);
    check_eq("frozen_digits", 32'({dig1, dig0}), 32'({7'h5B, 7'h06}));
    drive(7'h5B, 1'b0, 4);
    check_eq("resume_link", 32'(link), 32'h1);

    // Illegal glyph on digit 1.
    for (int i = 0; i < 8; i++) begin drive(7'h06, 1'b1, 2); drive(7'h49, 1'b0, 2); end
    check_eq("illegal_digit1", 32'(dig1), 32'h49);
`ifdef SEV_SEG_RX_DECODE_EN
    check_eq("illegal_valid", 32'(hexv), 32'h1);
`endif

    // Randomized phases, holds, glitches, freezes and occasional resets.
    for (int i = 0; i < 400; i++) begin
      logic [6:0] v;
      int r;
      r = int'($urandom_range(0, 99));
      v = (r < 10) ? 7'($urandom) : pool[$urandom_range(0, 5)];
      if (r == 99) begin
        rst = 1'b1; @(negedge clk); rst = 1'b0;
      end else if (r == 98) begin
        drive(v, pins_cath, P_TMO + 3);
      end else begin
        drive(v, ~pins_cath, int'($urandom_range(1, 5)));
      end
    end

    // Reset mid-capture clears everything on the next cycle.
    for (int i = 0; i < 3; i++) begin drive(7'h77, 1'b1, 2); drive(7'h49, 1'b0, 2); end
    drive(7'h39, 1'b1, 1);
    rst = 1'b1;
    @(negedge clk);
    check_eq("midrst_digits", 32'({dig1, dig0}), 32'h0);
    check_eq("midrst_flags", 32'({upd, link}), 32'h0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
